// File: rtl/monkey_collision_detector_if.sv
// Collision interface between the VGA object drawers and the monkey
// movement logic. The master side supplies the pixel stream and drawing
// requests; the slave side (the collision detector) returns the
// per-frame collision report.
interface monkey_collision_detector_if;
  logic        startOfFrame;
  logic        monkeyDR;
  logic        wallDR;
  logic        ladderDR;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        wallCollision;
  logic        ladderCollision;
  logic [3:0]  HitEdgeCode;

  modport master (
    output startOfFrame, monkeyDR, wallDR, ladderDR,
    output offsetX, offsetY, pixelX, pixelY,
    input  wallCollision, ladderCollision, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, monkeyDR, wallDR, ladderDR,
    input  offsetX, offsetY, pixelX, pixelY,
    output wallCollision, ladderCollision, HitEdgeCode
  );
endinterface

// File: rtl/monkey_collision_detector.sv
// monkey_collision_detector
// Accumulates monkey/wall and monkey/ladder overlap pixels over a frame,
// classifies wall overlaps by sprite zone, and at the next frame boundary
// issues one resolved report (wallCollision / ladderCollision pulses and a
// held HitEdgeCode) one cycle after the closing startOfFrame.
// Optional feature: define MONKEY_SCREEN_EDGE_EN to treat the left and right
// screen borders (pixelX == 0 / 639) as walls for monkey pixels.
module monkey_collision_detector #(
  parameter int OBJECT_WIDTH  = 64,
  parameter int OBJECT_HEIGHT = 64,
  parameter int EDGE_W        = 8,
  parameter int EDGE_H        = 8,
  parameter int MIN_HITS      = 2
) (
  input  logic clk,
  input  logic resetN,
  monkey_collision_detector_if.slave bus
);

  // Zone indices into the hit/threshold vectors; index 5 is the ladder.
  localparam int Z_BOTTOM = 0;
  localparam int Z_TOP    = 1;
  localparam int Z_LEFT   = 2;
  localparam int Z_RIGHT  = 3;
  localparam int Z_INNER  = 4;
  localparam int Z_LADDER = 5;
  localparam int N_CNT    = 6;

  localparam logic [10:0] BOTTOM_Y = 11'(OBJECT_HEIGHT - EDGE_H);
  localparam logic [10:0] TOP_Y    = 11'(EDGE_H);
  localparam logic [10:0] LEFT_X   = 11'(EDGE_W);
  localparam logic [10:0] RIGHT_X  = 11'(OBJECT_WIDTH - EDGE_W);
  localparam logic [7:0]  MIN_C    = 8'(MIN_HITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } stateT;

  stateT stateReg, stateNext;
  logic  holdZero;     // counters forced to zero (no frame in progress)
  logic  closeFrame;   // frame boundary: snapshot report, restart counters

  logic [N_CNT-1:0] hitVec;
  logic [N_CNT-1:0] overVec;
  logic [4:0]       zoneSel;
  logic             wallPix;
  logic [3:0]       codeNext;

  logic       wallColReg;
  logic       ladderColReg;
  logic [3:0] codeReg;

`ifdef MONKEY_SCREEN_EDGE_EN
  localparam logic [10:0] SCREEN_RIGHT_X = 11'd639;
  logic screenLeft;
  logic screenRight;
  logic unusedPixels;
  assign unusedPixels = ^bus.pixelY;
`else
  logic unusedPixels;
  assign unusedPixels = ^{bus.pixelX, bus.pixelY};
`endif

  // Sprite-zone classification of the current pixel, bottom band first.
  always_comb begin
    zoneSel = 5'b0;
    if (bus.offsetY >= BOTTOM_Y)     zoneSel[Z_BOTTOM] = 1'b1;
    else if (bus.offsetY < TOP_Y)    zoneSel[Z_TOP]    = 1'b1;
    else if (bus.offsetX < LEFT_X)   zoneSel[Z_LEFT]   = 1'b1;
    else if (bus.offsetX >= RIGHT_X) zoneSel[Z_RIGHT]  = 1'b1;
    else                             zoneSel[Z_INNER]  = 1'b1;
  end

  // Per-pixel hit vector: one wall zone at most, plus the ladder bit.
  always_comb begin
    wallPix = bus.monkeyDR && bus.wallDR;
    hitVec  = '0;
    hitVec[Z_LADDER] = bus.monkeyDR && bus.ladderDR;
`ifdef MONKEY_SCREEN_EDGE_EN
    // A screen-border pixel is a single side hit even if wallDR is also set.
    screenLeft  = bus.monkeyDR && (bus.pixelX == 11'd0);
    screenRight = bus.monkeyDR && (bus.pixelX == SCREEN_RIGHT_X);
    if (screenLeft)       hitVec[Z_LEFT]  = 1'b1;
    else if (screenRight) hitVec[Z_RIGHT] = 1'b1;
    else if (wallPix)     hitVec[4:0]     = zoneSel;
`else
    if (wallPix)          hitVec[4:0]     = zoneSel;
`endif
  end

  // Five wall-zone counters and the ladder counter, 8-bit saturating.
  genvar gi;
  generate
    for (gi = 0; gi < N_CNT; gi++) begin : gCnt
      logic [7:0] cntReg;
      // Count this zone's hit pixels; a hit in the closing cycle starts the new frame.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                              cntReg <= '0;
        else if (holdZero)                        cntReg <= '0;
        else if (closeFrame)                      cntReg <= {7'd0, hitVec[gi]};
        else if (hitVec[gi] && cntReg != 8'hFF)   cntReg <= cntReg + 8'd1;
      end
      assign overVec[gi] = (cntReg >= MIN_C);
    end
  endgenerate

  // Edge code resolution: embedded beats bottom, left, right, top.
  always_comb begin
    codeNext = 4'b0000;
    if (overVec[Z_INNER])       codeNext = 4'b1111;
    else if (overVec[Z_BOTTOM]) codeNext = 4'b0001;
    else if (overVec[Z_LEFT])   codeNext = 4'b1000;
    else if (overVec[Z_RIGHT])  codeNext = 4'b0010;
    else if (overVec[Z_TOP])    codeNext = 4'b0100;
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  // Next state and counter control; REPORT is a single cycle unless a new
  // frame boundary arrives in it, in which case it reports again.
  always_comb begin
    stateNext  = stateReg;
    holdZero   = 1'b0;
    closeFrame = 1'b0;
    case (stateReg)
      IDLE: begin
        holdZero = 1'b1;
        if (bus.startOfFrame) stateNext = ACCUM;
      end
      ACCUM: begin
        if (bus.startOfFrame) begin
          closeFrame = 1'b1;
          stateNext  = REPORT;
        end
      end
      REPORT: begin
        if (bus.startOfFrame) begin
          closeFrame = 1'b1;
          stateNext  = REPORT;
        end else begin
          stateNext  = ACCUM;
        end
      end
      default: begin
        holdZero  = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  // Frame summary: pulses are registered so they appear in the REPORT cycle,
  // one cycle after the closing startOfFrame; the edge code holds until the next report.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wallColReg   <= 1'b0;
      ladderColReg <= 1'b0;
      codeReg      <= 4'b0000;
    end else begin
      wallColReg   <= closeFrame && (|overVec[4:0]);
      ladderColReg <= closeFrame && overVec[Z_LADDER];
      if (closeFrame) codeReg <= codeNext;
    end
  end

  assign bus.wallCollision   = wallColReg;
  assign bus.ladderCollision = ladderColReg;
  assign bus.HitEdgeCode     = codeReg;

endmodule

// File: tb/tb_monkey_collision_detector.sv
// Directed self-checking bench for monkey_collision_detector.
module tb_monkey_collision_detector;
  logic clk;
  logic resetN;
  int   total;
  int   bad;

  monkey_collision_detector_if bus ();

  monkey_collision_detector dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns #1 after the rising edge with inputs idle.
  task automatic drive(input logic sof, input logic m, input logic w, input logic l,
                       input logic [10:0] ox, input logic [10:0] oy, input logic [10:0] px);
    bus.startOfFrame = sof;
    bus.monkeyDR     = m;
    bus.wallDR       = w;
    bus.ladderDR     = l;
    bus.offsetX      = ox;
    bus.offsetY      = oy;
    bus.pixelX       = px;
    bus.pixelY       = 11'd100;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.monkeyDR     = 1'b0;
    bus.wallDR       = 1'b0;
    bus.ladderDR     = 1'b0;
    bus.pixelX       = 11'd320;
  endtask

  task automatic wallHits(input int n, input logic [10:0] ox, input logic [10:0] oy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, ox, oy, 11'd320);
  endtask

  task automatic frameEnd();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd320);
  endtask

  task automatic idleCycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd320);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.monkeyDR = 1'b0;
    bus.wallDR = 1'b0;
    bus.ladderDR = 1'b0;
    bus.offsetX = '0;
    bus.offsetY = '0;
    bus.pixelX = 11'd320;
    bus.pixelY = 11'd100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("rst_ladder", {3'b0, bus.ladderCollision}, 4'h0);
    chk("rst_code", bus.HitEdgeCode, 4'h0);
    resetN = 1'b1;
    idleCycle();

    // Partial frame after reset: no report.
    wallHits(3, 11'd30, 11'd60);
    frameEnd();
    chk("first_sof_no_pulse", {3'b0, bus.wallCollision}, 4'h0);

    // Bottom band, 3 pixels.
    wallHits(3, 11'd30, 11'd60);
    bus.startOfFrame = 1'b1;
    #2;
    chk("no_pulse_in_sof_cycle", {3'b0, bus.wallCollision}, 4'h0);
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    chk("bottom_wall", {3'b0, bus.wallCollision}, 4'h1);
    chk("bottom_code", bus.HitEdgeCode, 4'b0001);
    chk("bottom_ladder", {3'b0, bus.ladderCollision}, 4'h0);
    idleCycle();
    chk("pulse_width", {3'b0, bus.wallCollision}, 4'h0);
    wallHits(1, 11'd2, 11'd30);
    idleCycle();
    chk("code_held", bus.HitEdgeCode, 4'b0001);

    // Single left pixel (finishes the frame started above): below threshold.
    frameEnd();
    chk("left1_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("left1_code", bus.HitEdgeCode, 4'b0000);

    // Two left pixels.
    wallHits(2, 11'd2, 11'd30);
    frameEnd();
    chk("left2_wall", {3'b0, bus.wallCollision}, 4'h1);
    chk("left2_code", bus.HitEdgeCode, 4'b1000);

    // Left band plus interior: embedded.
    wallHits(2, 11'd2, 11'd30);
    wallHits(2, 11'd30, 11'd30);
    frameEnd();
    chk("embed_code", bus.HitEdgeCode, 4'b1111);

    // Ladder only.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 11'd30, 11'd30, 11'd320);
    frameEnd();
    chk("ladder_pulse", {3'b0, bus.ladderCollision}, 4'h1);
    chk("ladder_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("ladder_code", bus.HitEdgeCode, 4'b0000);

    // Right beats top; top alone.
    wallHits(2, 11'd30, 11'd2);
    wallHits(2, 11'd60, 11'd30);
    frameEnd();
    chk("right_over_top", bus.HitEdgeCode, 4'b0010);
    wallHits(2, 11'd30, 11'd2);
    frameEnd();
    chk("top_code", bus.HitEdgeCode, 4'b0100);

    // Drawing requests without the monkey, and monkey without wall: no hits.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 11'd30, 11'd60, 11'd320);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 11'd30, 11'd60, 11'd320);
    frameEnd();
    chk("no_overlap_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("no_overlap_ladder", {3'b0, bus.ladderCollision}, 4'h0);

    // Saturation: 257 bottom pixels must not wrap below threshold.
    wallHits(257, 11'd30, 11'd60);
    frameEnd();
    chk("sat_wall", {3'b0, bus.wallCollision}, 4'h1);
    chk("sat_code", bus.HitEdgeCode, 4'b0001);

    // Hit in the closing cycle belongs to the next frame.
    wallHits(1, 11'd2, 11'd30);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 11'd2, 11'd30, 11'd320);
    chk("sof_hit_old_frame", bus.HitEdgeCode, 4'b0000);
    wallHits(1, 11'd2, 11'd30);
    frameEnd();
    chk("sof_hit_new_frame", bus.HitEdgeCode, 4'b1000);

    // Back-to-back frame boundaries.
    wallHits(2, 11'd30, 11'd60);
    frameEnd();
    chk("b2b_first_wall", {3'b0, bus.wallCollision}, 4'h1);
    frameEnd();
    chk("b2b_second_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("b2b_second_code", bus.HitEdgeCode, 4'b0000);
    idleCycle();

    // Reset during REPORT clears outputs at once.
    wallHits(2, 11'd30, 11'd60);
    frameEnd();
    resetN = 1'b0;
    #1;
    chk("rst_in_report_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("rst_in_report_code", bus.HitEdgeCode, 4'b0000);
    idleCycle();
    resetN = 1'b1;
    frameEnd();

    // Reset mid-frame discards the hits made before it.
    wallHits(10, 11'd30, 11'd60);
    resetN = 1'b0;
    idleCycle();
    resetN = 1'b1;
    frameEnd();
    chk("rst_mid_no_pulse", {3'b0, bus.wallCollision}, 4'h0);
    wallHits(2, 11'd2, 11'd30);
    frameEnd();
    chk("rst_mid_after_wall", {3'b0, bus.wallCollision}, 4'h1);
    chk("rst_mid_after_code", bus.HitEdgeCode, 4'b1000);

    // Screen right border without wallDR.
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 11'd63, 11'd30, 11'd639);
    frameEnd();
`ifdef MONKEY_SCREEN_EDGE_EN
    chk("screen_edge_wall", {3'b0, bus.wallCollision}, 4'h1);
    chk("screen_edge_code", bus.HitEdgeCode, 4'b0010);
`else
    chk("screen_edge_wall", {3'b0, bus.wallCollision}, 4'h0);
    chk("screen_edge_code", bus.HitEdgeCode, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
